// File: rtl/vu_vmu_pkg.sv
// Shared VMU definitions: default widths, UT cmdcode field positions, addrgen FSM encoding.
// Latency: n/a (package).
// Backpressure: n/a (package).
package vu_vmu_pkg;

  // Default widths of the UT command path
  localparam int CMD_W  = 8;
  localparam int VLEN_W = 12;
  localparam int ADDR_W = 32;

  // Fields inside cmdcode; bits above the store flag carry nothing for this stage
  localparam int CMD_STORE_BIT = 4;
  localparam int CMD_TYP_LSB   = 0;
  localparam int CMD_TYP_W     = 4;

  // UT address generator sequencing
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_IMM = 2'd1,
    ST_RUN      = 2'd2
  } ut_state_t;

endpackage

// File: rtl/vu_vmu_out_slot.sv
// One-entry val/rdy pipe register carrying a W-bit payload.
// Latency: 1 cycle from enq fire to deq_val.
// Backpressure: enq_rdy = !deq_val | deq_rdy, so a simultaneous drain and load sustains 1/cycle.
module vu_vmu_out_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enq_val,
  output logic         enq_rdy,
  input  logic [W-1:0] enq_bits,
  output logic         deq_val,
  input  logic         deq_rdy,
  output logic [W-1:0] deq_bits
);

  // Slot can take a new entry when empty or when its current entry leaves this cycle
  assign enq_rdy = !deq_val || deq_rdy;

  // Load on enq fire (replacing any draining entry), otherwise drop the entry once taken
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deq_val  <= 1'b0;
      deq_bits <= '0;
    end else if (enq_val && enq_rdy) begin
      deq_val  <= 1'b1;
      deq_bits <= enq_bits;
    end else if (deq_rdy) begin
      deq_val  <= 1'b0;
    end
  end

endmodule

// File: rtl/vu_vmu_ut_addrgen.sv
// UT address generator: pops cmd, then imm, then vlen+1 bases and emits tagged base+imm element requests.
// Latency: utaq fire at t -> req_val at t+1; cmd -> imm -> first utaq each at least one cycle apart.
// Backpressure: utaq_rdy follows the one-entry output slot (!req_val | req_rdy); other queues wait on FSM state.
module vu_vmu_ut_addrgen #(
  parameter int CMD_W  = vu_vmu_pkg::CMD_W,
  parameter int VLEN_W = vu_vmu_pkg::VLEN_W,
  parameter int ADDR_W = vu_vmu_pkg::ADDR_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CMD_W+VLEN_W-1:0] vmu_utcmdq_bits,
  input  logic                    vmu_utcmdq_val,
  output logic                    vmu_utcmdq_rdy,
  input  logic [ADDR_W-1:0]       vmu_utimmq_bits,
  input  logic                    vmu_utimmq_val,
  output logic                    vmu_utimmq_rdy,
  input  logic [ADDR_W-1:0]       utaq_bits,
  input  logic                    utaq_val,
  output logic                    utaq_rdy,
  output logic [ADDR_W-1:0]       req_addr,
  output logic                    req_store,
  output logic [3:0]              req_typ,
  output logic [VLEN_W-1:0]       req_tag,
  output logic                    req_last,
  output logic                    req_val,
  input  logic                    req_rdy,
  output logic                    busy
);
  import vu_vmu_pkg::*;

  localparam int PAY_W = ADDR_W + 1 + CMD_TYP_W + VLEN_W + 1;

  ut_state_t              state;
  ut_state_t              state_nxt;
  logic                   cmd_fire;
  logic                   imm_fire;
  logic                   utaq_fire;
  logic                   slot_rdy;
  logic                   last_elem;
  logic                   store_q;
  logic [CMD_TYP_W-1:0]   typ_q;
  logic [VLEN_W-1:0]      vlen_q;
  logic [VLEN_W-1:0]      cnt_q;
  logic [ADDR_W-1:0]      imm_q;
  logic [ADDR_W-1:0]      addr_sum;
  logic [PAY_W-1:0]       slot_in;
  logic [PAY_W-1:0]       slot_out;
  logic                   cmd_hi_unused;

  // cmdcode bits above the store flag have no meaning here
  assign cmd_hi_unused = ^vmu_utcmdq_bits[CMD_W+VLEN_W-1:VLEN_W+CMD_STORE_BIT+1];

  assign cmd_fire  = vmu_utcmdq_val && vmu_utcmdq_rdy;
  assign imm_fire  = vmu_utimmq_val && vmu_utimmq_rdy;
  assign utaq_fire = utaq_val && utaq_rdy;

  // Counter never wraps inside a command, so equality with vlen marks the final element
  assign last_elem = (cnt_q == vlen_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: cmd, then imm, then stream elements until the last one is accepted
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (cmd_fire) state_nxt = ST_WAIT_IMM;
      ST_WAIT_IMM: if (imm_fire) state_nxt = ST_RUN;
      ST_RUN:      if (utaq_fire && last_elem) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Readies: one queue open per state, all closed while reset is held
  always_comb begin
    vmu_utcmdq_rdy = 1'b0;
    vmu_utimmq_rdy = 1'b0;
    utaq_rdy       = 1'b0;
    if (reset) begin
      case (state)
        ST_IDLE:     vmu_utcmdq_rdy = 1'b1;
        ST_WAIT_IMM: vmu_utimmq_rdy = 1'b1;
        ST_RUN:      utaq_rdy       = slot_rdy;
        default:     ;
      endcase
    end
  end

  // Command/immediate latches and the element counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_q <= 1'b0;
      typ_q   <= '0;
      vlen_q  <= '0;
      cnt_q   <= '0;
      imm_q   <= '0;
    end else begin
      if (cmd_fire) begin
        store_q <= vmu_utcmdq_bits[VLEN_W+CMD_STORE_BIT];
        typ_q   <= vmu_utcmdq_bits[VLEN_W+CMD_TYP_LSB +: CMD_TYP_W];
        vlen_q  <= vmu_utcmdq_bits[VLEN_W-1:0];
        cnt_q   <= '0;
      end else if (utaq_fire) begin
        cnt_q   <= cnt_q + 1'b1;
      end
      if (imm_fire) imm_q <= vmu_utimmq_bits;
    end
  end

  // Address wraps modulo 2^ADDR_W by truncation
  assign addr_sum = utaq_bits + imm_q;
  assign slot_in  = {addr_sum, store_q, typ_q, cnt_q, last_elem};

  vu_vmu_out_slot #(
    .W (PAY_W)
  ) u_out_slot (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (utaq_fire),
    .enq_rdy  (slot_rdy),
    .enq_bits (slot_in),
    .deq_val  (req_val),
    .deq_rdy  (req_rdy),
    .deq_bits (slot_out)
  );

  assign {req_addr, req_store, req_typ, req_tag, req_last} = slot_out;

  assign busy = (state != ST_IDLE) || req_val;

endmodule

// File: tb/tb_vu_vmu_ut_addrgen.sv
// Self-checking bench for vu_vmu_ut_addrgen: scoreboard of expected element requests.
// Inputs driven 1 time unit after posedge, outputs sampled on negedge.
// req_rdy pattern selectable: always-ready or 1,0,0 repeating.
module tb_vu_vmu_ut_addrgen;

  localparam int TMO = 10000;

  typedef struct packed {
    logic [31:0] addr;
    logic        store;
    logic [3:0]  typ;
    logic [11:0] tag;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] vmu_utcmdq_bits = '0;
  logic        vmu_utcmdq_val = 1'b0;
  logic        vmu_utcmdq_rdy;
  logic [31:0] vmu_utimmq_bits = '0;
  logic        vmu_utimmq_val = 1'b0;
  logic        vmu_utimmq_rdy;
  logic [31:0] utaq_bits = '0;
  logic        utaq_val = 1'b0;
  logic        utaq_rdy;
  logic [31:0] req_addr;
  logic        req_store;
  logic [3:0]  req_typ;
  logic [11:0] req_tag;
  logic        req_last;
  logic        req_val;
  logic        req_rdy = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int n_pop = 0;
  int first_cyc = 0;
  int span = 0;
  logic [31:0] last_addr = '0;
  logic [11:0] last_tag = '0;

  exp_t q[$];
  logic [7:0]  cur_code;
  logic [11:0] cur_vlen;
  logic [11:0] cur_tag;
  logic [31:0] cur_imm;

  vu_vmu_ut_addrgen dut (
    .clk             (clk),
    .reset           (reset),
    .vmu_utcmdq_bits (vmu_utcmdq_bits),
    .vmu_utcmdq_val  (vmu_utcmdq_val),
    .vmu_utcmdq_rdy  (vmu_utcmdq_rdy),
    .vmu_utimmq_bits (vmu_utimmq_bits),
    .vmu_utimmq_val  (vmu_utimmq_val),
    .vmu_utimmq_rdy  (vmu_utimmq_rdy),
    .utaq_bits       (utaq_bits),
    .utaq_val        (utaq_val),
    .utaq_rdy        (utaq_rdy),
    .req_addr        (req_addr),
    .req_store       (req_store),
    .req_typ         (req_typ),
    .req_tag         (req_tag),
    .req_last        (req_last),
    .req_val         (req_val),
    .req_rdy         (req_rdy),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle counter
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sink ready pattern
  initial begin
    int k;
    k = 0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      req_rdy = (rdy_mode == 0) ? 1'b1 : ((k % 3) == 0);
    end
  end

  // Monitor: compare drained requests against the scoreboard, watch ready exclusivity
  initial forever begin
    exp_t e;
    @(negedge clk);
    check("one_queue_open", 64'($countones({vmu_utcmdq_rdy, vmu_utimmq_rdy, utaq_rdy}) <= 1), 64'd1);
    if (req_val && !req_rdy) check("utaq_rdy_slot_full", utaq_rdy, 0);
    if (req_val && req_rdy) begin
      if (q.size() == 0) begin
        check("unexpected_req", 1, 0);
      end else begin
        e = q.pop_front();
        check("req_addr",  req_addr,  e.addr);
        check("req_store", req_store, e.store);
        check("req_typ",   req_typ,   e.typ);
        check("req_tag",   req_tag,   e.tag);
        check("req_last",  req_last,  e.last);
        n_pop++;
        last_addr = req_addr;
        last_tag  = req_tag;
        if (req_tag == 12'd0) first_cyc = cyc;
        if (req_last) span = cyc - first_cyc;
      end
    end
  end

  task automatic send_cmd(input logic [7:0] code, input logic [11:0] vlen);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    cur_code = code;
    cur_vlen = vlen;
    cur_tag  = '0;
    @(posedge clk);
    #1;
    vmu_utcmdq_bits = {code, vlen};
    vmu_utcmdq_val  = 1'b1;
    while (!done && t < 100) begin
      @(negedge clk);
      if (vmu_utcmdq_rdy) done = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    vmu_utcmdq_val = 1'b0;
    check("cmd_accept", done, 1);
  endtask

  task automatic send_imm(input logic [31:0] imm);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    cur_imm = imm;
    vmu_utimmq_bits = imm;
    vmu_utimmq_val  = 1'b1;
    while (!done && t < 100) begin
      @(negedge clk);
      if (vmu_utimmq_rdy) done = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    vmu_utimmq_val = 1'b0;
    check("imm_accept", done, 1);
  endtask

  // Feed n bases b0, b0+stride, ...; push the expected request on every utaq fire
  task automatic feed(input logic [31:0] b0, input logic [31:0] stride, input int n);
    int i;
    int t;
    exp_t e;
    i = 0;
    t = 0;
    utaq_bits = b0;
    utaq_val  = 1'b1;
    while (i < n && t < TMO) begin
      @(negedge clk);
      if (utaq_rdy) begin
        e.addr  = utaq_bits + cur_imm;
        e.store = cur_code[4];
        e.typ   = cur_code[3:0];
        e.tag   = cur_tag;
        e.last  = (cur_tag == cur_vlen);
        q.push_back(e);
        cur_tag = cur_tag + 12'd1;
        i++;
      end
      @(posedge clk);
      #1;
      utaq_bits = b0 + stride * 32'(i);
      t++;
    end
    utaq_val = 1'b0;
    check("feed_done", 64'(i), 64'(n));
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((q.size() != 0 || req_val) && t < TMO) begin
      @(negedge clk);
      t++;
    end
    check("drain_in_time", 64'(t < TMO), 64'd1);
  endtask

  task automatic run(input logic [7:0] code, input logic [11:0] vlen, input logic [31:0] imm,
                     input logic [31:0] b0, input logic [31:0] stride);
    send_cmd(code, vlen);
    send_imm(imm);
    feed(b0, stride, int'(vlen) + 1);
  endtask

  initial begin
    int p0;
    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmdq_rdy", vmu_utcmdq_rdy, 0);
    check("rst_immq_rdy", vmu_utimmq_rdy, 0);
    check("rst_utaq_rdy", utaq_rdy, 0);
    check("rst_req_val",  req_val, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_req_tag",  req_tag, 0);
    check("rst_busy",     busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("idle_cmdq_rdy", vmu_utcmdq_rdy, 1);
    check("idle_immq_rdy", vmu_utimmq_rdy, 0);
    check("idle_utaq_rdy", utaq_rdy, 0);

    // Single element
    run(8'h03, 12'd0, 32'h10, 32'h1000, 32'h0);
    wait_drain();
    check("single_addr", last_addr, 32'h1010);
    check("busy_after_drain", busy, 0);

    // Four elements, sink always ready: back-to-back output
    p0 = n_pop;
    run(8'h15, 12'd3, 32'h8, 32'h100, 32'h100);
    wait_drain();
    check("four_count", 64'(n_pop - p0), 64'd4);
    check("four_consecutive_span", 64'(span), 64'd3);
    check("four_last_addr", last_addr, 32'h408);

    // Same with throttled sink; upper cmdcode bits set and ignored
    rdy_mode = 1;
    p0 = n_pop;
    run(8'hE2, 12'd3, 32'h8, 32'h100, 32'h100);
    wait_drain();
    check("throttled_count", 64'(n_pop - p0), 64'd4);
    rdy_mode = 0;

    // Address wrap
    run(8'h01, 12'd0, 32'h10, 32'hFFFF_FFF8, 32'h0);
    wait_drain();
    check("wrap_addr", last_addr, 32'h0000_0008);

    // Maximum length command
    p0 = n_pop;
    run(8'h12, 12'hFFF, 32'h4, 32'h0, 32'h4);
    wait_drain();
    check("max_count", 64'(n_pop - p0), 64'd4096);
    check("max_last_tag", last_tag, 12'hFFF);
    check("max_back_idle", vmu_utcmdq_rdy, 1);

    // Reset while the second of four elements sits in the slot
    send_cmd(8'h13, 12'd3);
    send_imm(32'h20);
    feed(32'h500, 32'h10, 2);
    check("pre_reset_req_val", req_val, 1);
    reset = 1'b0;
    #1;
    check("mid_rst_req_val",  req_val, 0);
    check("mid_rst_req_addr", req_addr, 0);
    check("mid_rst_cmdq_rdy", vmu_utcmdq_rdy, 0);
    check("mid_rst_immq_rdy", vmu_utimmq_rdy, 0);
    check("mid_rst_utaq_rdy", utaq_rdy, 0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_cmdq_rdy", vmu_utcmdq_rdy, 1);
    check("post_rst_immq_rdy", vmu_utimmq_rdy, 0);
    check("post_rst_utaq_rdy", utaq_rdy, 0);
    check("post_rst_busy", busy, 0);
    p0 = n_pop;
    run(8'h04, 12'd1, 32'h0, 32'h700, 32'h4);
    wait_drain();
    check("post_rst_count", 64'(n_pop - p0), 64'd2);
    check("post_rst_last_addr", last_addr, 32'h704);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
